// File: rtl/fifo_rd_serializer.sv
// Read-side consumer for async_fifo: pops DSIZE-bit words and emits them as an
// OSIZE-bit valid/ready stream, least-significant slice first, with no bubbles.
module fifo_rd_serializer #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned OSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic [OSIZE-1:0] odata,
  output logic             ovalid,
  input  logic             oready,
  output logic             olast,
  output logic [15:0]      pop_cnt
);

  localparam int unsigned Ratio = DSIZE / OSIZE;
  localparam int unsigned IdxW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  if ((DSIZE % OSIZE) != 0 || Ratio < 2) begin : gen_bad_params
    $error("fifo_rd_serializer: DSIZE must be a multiple of OSIZE with ratio >= 2");
  end

  logic [DSIZE-1:0]            hold_data_q;
  logic                        hold_valid_q;
  logic [IdxW-1:0]             idx_q;
  logic [15:0]                 pop_cnt_q;
  logic                        fire;
  logic                        at_last;
  logic [Ratio-1:0][OSIZE-1:0] slices;

  assign fire    = hold_valid_q & oready;
  assign at_last = (idx_q == LastIdx);

  // Prefetch on the final slice's handshake so a busy FIFO drains gap-free.
  assign rinc = rrst_n & ~rempty & (~hold_valid_q | (fire & at_last));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      idx_q        <= '0;
      pop_cnt_q    <= '0;
    end else if (rinc) begin
      hold_data_q  <= rdata;
      hold_valid_q <= 1'b1;
      idx_q        <= '0;
      pop_cnt_q    <= pop_cnt_q + 16'd1;
    end else if (fire) begin
      // Here a last-slice fire implies rempty, so the word is simply retired.
      if (at_last) begin
        hold_valid_q <= 1'b0;
        idx_q        <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign slices  = hold_data_q;
  assign odata   = slices[idx_q];
  assign ovalid  = hold_valid_q;
  assign olast   = hold_valid_q & at_last;
  assign pop_cnt = pop_cnt_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: FWFT FIFO model, slice scoreboard, rule checks,
// a directed vector table and randomized traffic.
module tb_fifo_rd_serializer;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        rinc;
  logic [31:0] rdata = 32'hBAD0BAD0;
  logic        rempty = 1'b1;
  logic [7:0]  odata;
  logic        ovalid;
  logic        oready = 1'b0;
  logic        olast;
  logic [15:0] pop_cnt;

  fifo_rd_serializer #(.DSIZE(32), .OSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rinc    (rinc),
    .rdata   (rdata),
    .rempty  (rempty),
    .odata   (odata),
    .ovalid  (ovalid),
    .oready  (oready),
    .olast   (olast),
    .pop_cnt (pop_cnt)
  );

  always #5 rclk = ~rclk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] push_q[$];
  logic [8:0]  exp_q[$];  // {last, slice}
  logic [7:0]  got_q[$];
  int          model_pops = 0;
  int          rinc_seen = 0;
  int          cyc = 0;
  int          first_fire = -1;
  int          last_fire = -1;
  logic        exp_drain = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_odata = '0;
  logic        prev_olast = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  rdy_pat;  // oready per cycle, bit c%8
    logic [31:0] exp;      // slices in emit order, first in [31:24]
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic upd_pins();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 32'hBAD0BAD0 : fifo_q[0];
  endtask

  // One rclk cycle: sample/check at negedge, then advance the FIFO model after posedge.
  task automatic tick();
    logic       s_rinc;
    logic       fire;
    logic [8:0] e;
    logic [31:0] w;
    @(negedge rclk);
    cyc++;
    if (!rrst_n) begin
      check("reset_rinc", rinc, 0);
      check("reset_ovalid", ovalid, 0);
      check("reset_pop_cnt", pop_cnt, 0);
    end
    if (rempty) check("rinc_when_empty", rinc, 0);
    else if (rrst_n && !ovalid) check("rinc_latency", rinc, 1);
    if (ovalid && !(oready && olast)) check("rinc_mid_word", rinc, 0);
    if (exp_drain) check("drain_ovalid", ovalid, 0);
    if (stall_prev) begin
      check("stall_ovalid", ovalid, 1);
      check("stall_odata", odata, prev_odata);
      check("stall_olast", olast, prev_olast);
    end
    fire = ovalid && oready;
    if (fire) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_slice: got %0h required none", odata);
      end else begin
        e = exp_q.pop_front();
        check("odata", odata, e[7:0]);
        check("olast", olast, e[8]);
      end
      got_q.push_back(odata);
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
    end
    exp_drain  = fire && olast && rempty;
    stall_prev = ovalid && !oready;
    prev_odata = odata;
    prev_olast = olast;
    s_rinc     = rinc;
    @(posedge rclk);
    #1;
    if (s_rinc) begin
      w = fifo_q.pop_front();
      model_pops++;
      rinc_seen++;
      for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), w[8*k +: 8]});
    end
    if (push_q.size() > 0 && fifo_q.size() < 16) fifo_q.push_back(push_q.pop_front());
    upd_pins();
    check("pop_cnt", pop_cnt, model_pops[15:0]);
  endtask

  // Asynchronous assert between edges; the partially emitted word is dropped.
  task automatic do_reset(input int cycles);
    #2;
    rrst_n = 1'b0;
    #1;
    check("rst_async_ovalid", ovalid, 0);
    check("rst_async_olast", olast, 0);
    check("rst_async_odata", odata, 0);
    check("rst_async_rinc", rinc, 0);
    check("rst_async_pop_cnt", pop_cnt, 0);
    exp_q.delete();
    model_pops = 0;
    exp_drain  = 1'b0;
    stall_prev = 1'b0;
    for (int c = 0; c < cycles; c++) tick();
    rrst_n = 1'b1;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{word: 32'hA1B2C3D4, rdy_pat: 8'hFF, exp: 32'hD4C3B2A1};
    vecs[1] = '{word: 32'h11223344, rdy_pat: 8'h99, exp: 32'h44332211};
    vecs[2] = '{word: 32'hDEADBEEF, rdy_pat: 8'h55, exp: 32'hEFBEADDE};
    vecs[3] = '{word: 32'h5A5A0F0F, rdy_pat: 8'h03, exp: 32'h0F0F5A5A};

    // Reset idle with a non-empty FIFO for 100 ns.
    fifo_q.push_back(32'h55AA55AA);
    upd_pins();
    #1;
    for (int c = 0; c < 10; c++) tick();
    rrst_n = 1'b1;
    #3;
    check("rinc_after_release", rinc, 1);
    for (int c = 0; c < 3; c++) tick();
    oready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check("idle_after_first", ovalid, 0);

    // Directed vector table.
    foreach (vecs[i]) begin
      int base_pops;
      int base_rinc;
      base_pops = model_pops;
      base_rinc = rinc_seen;
      got_q.delete();
      push_q.push_back(vecs[i].word);
      for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
        oready = vecs[i].rdy_pat[c % 8];
        tick();
      end
      oready = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      check("vec_nslices", got_q.size(), 4);
      for (int k = 0; k < 4 && k < got_q.size(); k++)
        check("vec_slice", got_q[k], vecs[i].exp[31 - 8*k -: 8]);
      check("vec_pop_cnt", pop_cnt, base_pops + 1);
      check("vec_rinc_count", rinc_seen - base_rinc, 1);
      check("vec_ovalid_after", ovalid, 0);
    end

    // Back-to-back words 0..9: 40 slices on consecutive cycles.
    begin
      int base_rinc;
      base_rinc  = rinc_seen;
      got_q.delete();
      first_fire = -1;
      for (int i = 0; i < 10; i++) fifo_q.push_back(i);
      upd_pins();
      oready = 1'b1;
      for (int c = 0; c < 60; c++) tick();
      check("b2b_nslices", got_q.size(), 40);
      check("b2b_span", last_fire - first_fire, 39);
      check("b2b_rinc_count", rinc_seen - base_rinc, 10);
      for (int k = 0; k < 40 && k < got_q.size(); k++)
        check("b2b_slice", got_q[k], (k % 4 == 0) ? (k / 4) : 0);
    end

    // Full 16-word FIFO drained in order.
    for (int i = 0; i < 16; i++) fifo_q.push_back($urandom);
    upd_pins();
    for (int c = 0; c < 70; c++) tick();
    check("full_drain_empty", rempty, 1);
    check("full_drain_exp", exp_q.size(), 0);

    // Reset mid-word: accept EF of DEADBEEF, then pulse reset.
    got_q.delete();
    push_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 10 && got_q.size() < 1; c++) tick();
    oready = 1'b0;
    check("midword_first", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'hEF);
    do_reset(2);
    got_q.delete();
    push_q.push_back(32'h01020304);
    oready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("midword_nslices", got_q.size(), 4);
    check("midword_slice0", (got_q.size() > 0) ? got_q[0] : 8'hFF, 8'h04);
    check("midword_pop_cnt", pop_cnt, 1);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1 && push_q.size() < 4) push_q.push_back($urandom);
      oready = ($urandom_range(0, 9) < 7);
      tick();
    end
    oready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && push_q.size() == 0 && !ovalid) break;
      tick();
    end
    check("rand_drain_done",
          (exp_q.size() == 0 && fifo_q.size() == 0 && push_q.size() == 0 && !ovalid), 1);
    check("rand_pop_cnt", pop_cnt, model_pops[15:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
